ps2_command_tx: RTL and testbench

PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

---
 rtl/ps2_command_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_command_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10-bit frame, acknowledge check.
// Define PS2_TX_TIMEOUT_EN to add a per-transfer watchdog that forces ERROR after TIMEOUT_CYCLES.
module ps2_command_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] cmd_data,
   input  logic       cmd_send,
   output logic       cmd_busy,
   output logic       cmd_done,
   output logic       cmd_error,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in,
   output logic       ps2_clock_drive,
   output logic       ps2_data_drive,
   output logic [2:0] fsm_state
);

   // Handshake: cmd_send is a one-cycle request honoured only while cmd_busy is low (IDLE);
   // requests seen while busy are dropped, and cmd_done/cmd_error close every accepted request.

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQUEST,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

   if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ps2_command_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
   end

   state_t           state;
   state_t           next_state;
   logic             clk_meta;
   logic             clk_sync;
   logic             clk_prev;
   logic             data_meta;
   logic             data_sync;
   logic             clk_fall;
   logic [8:0]       frame;
   logic [3:0]       bit_cnt;
   logic [INH_W-1:0] inhibit_cnt;
   logic             inhibit_last;
   logic             wd_expire;

   // Synchronizers reset to 1 so a released bus never looks like a falling edge.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clock_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   assign clk_fall     = clk_prev & ~clk_sync;
   assign inhibit_last = (inhibit_cnt == INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wd_cnt <= '0;
      end else if (state == S_IDLE) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES - 1)) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wd_expire = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR) &&
                      (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (cmd_send) next_state = S_INHIBIT;
         S_INHIBIT:   if (inhibit_last) next_state = S_REQUEST;
         S_REQUEST:   if (clk_fall) next_state = S_SHIFT;
         // The edge that moves past parity releases the line for the stop bit.
         S_SHIFT:     if (clk_fall && bit_cnt == 4'd8) next_state = S_ACK;
         S_ACK:       if (clk_fall) next_state = data_sync ? S_ERROR : S_WAIT_IDLE;
         S_WAIT_IDLE: if (clk_sync && data_sync) next_state = S_DONE;
         S_DONE:      next_state = S_IDLE;
         S_ERROR:     next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
      if (wd_expire) next_state = S_ERROR;
   end

   // frame[0] is the bit currently presented; the first falling edge (in REQUEST) presents data bit 0.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         frame       <= '0;
         bit_cnt     <= '0;
         inhibit_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_send) begin
                  frame       <= {~^cmd_data, cmd_data};
                  bit_cnt     <= '0;
                  inhibit_cnt <= '0;
               end
            end
            S_INHIBIT: inhibit_cnt <= inhibit_cnt + 1'b1;
            S_SHIFT: begin
               if (clk_fall && bit_cnt != 4'd9) begin
                  frame   <= {1'b0, frame[8:1]};
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ps2_clock_drive = 1'b0;
      ps2_data_drive  = 1'b0;
      case (state)
         S_INHIBIT: begin
            ps2_clock_drive = 1'b1;
            ps2_data_drive  = inhibit_last;
         end
         S_REQUEST: ps2_data_drive = 1'b1;
         S_SHIFT:   ps2_data_drive = ~frame[0];
         default: ;
      endcase
   end

   assign cmd_busy  = (state != S_IDLE);
   assign cmd_done  = (state == S_DONE);
   assign cmd_error = (state == S_ERROR);
   assign fsm_state = state;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: open-drain bus model with a keyboard-side device task and a frame scoreboard.
module tb_ps2_command_tx;

  localparam int INHIBIT    = 5000;
  localparam int TB_TIMEOUT = 12000;
  localparam int HALF       = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_send = 1'b0;
  logic       cmd_busy;
  logic       cmd_done;
  logic       cmd_error;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_drive;
  logic       ps2_data_drive;
  logic [2:0] fsm_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];

  // open-drain wired-AND of host and device
  assign ps2_clock_in = ~(ps2_clock_drive | dev_clk_low);
  assign ps2_data_in  = ~(ps2_data_drive | dev_data_low);

  ps2_command_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .cmd_data(cmd_data),
    .cmd_send(cmd_send),
    .cmd_busy(cmd_busy),
    .cmd_done(cmd_done),
    .cmd_error(cmd_error),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clock_drive(ps2_clock_drive),
    .ps2_data_drive(ps2_data_drive),
    .fsm_state(fsm_state)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded 2000000 time units");
    $fatal(1, "global timeout");
  end

  // passive monitor, sampled on the falling clock edge
  int done_cycles = 0, error_cycles = 0, overlap = 0, idle_drive = 0;
  int inhibit_run = 0, last_run = 0, inhibit_runs = 0, start_run = 0;
  int done_cyc = -1, error_cyc = -1, busy_rise_cyc = -1, busy_cycles = 0;
  logic busy_q = 1'b0;

  always @(negedge clock) begin
    if (cmd_done) begin done_cycles++; done_cyc = cyc; end
    if (cmd_error) begin error_cycles++; error_cyc = cyc; end
    if (cmd_done && cmd_error) overlap++;
    if ((!cmd_busy || cmd_done || cmd_error) && (ps2_clock_drive || ps2_data_drive)) idle_drive++;
    if (cmd_busy) busy_cycles++;
    if (cmd_busy && !busy_q) busy_rise_cyc = cyc;
    busy_q = cmd_busy;
    if (ps2_clock_drive) begin
      if (inhibit_run == 0) start_run = 0;
      inhibit_run++;
      if (ps2_data_drive && start_run == 0) start_run = inhibit_run;
    end else if (inhibit_run != 0) begin
      last_run = inhibit_run;
      inhibit_runs++;
      inhibit_run = 0;
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [7:0] d, output int acc);
    @(negedge clock);
    cmd_data = d;
    cmd_send = 1'b1;
    acc = cyc + 1;
    @(negedge clock);
    cmd_send = 1'b0;
  endtask

  task automatic wait_request(input string tag, output bit ok);
    int t;
    t = 0;
    ok = 1'b1;
    while (ps2_clock_drive !== 1'b1 && t < 20000) begin @(negedge clock); t++; end
    while (ps2_clock_drive !== 1'b0 && t < 20000) begin @(negedge clock); t++; end
    if (t >= 20000) begin
      compared++; mismatched++; ok = 1'b0;
      $display("FAIL %s_request inhibit then release not observed within 20000 cycles", tag);
      return;
    end
    compared++;
    if (ps2_data_in !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_start_bit got %b want 0", tag, ps2_data_in);
    end
  endtask

  // keyboard model: 11 clocks, samples data before each rising edge, optional ack on the 11th
  task automatic device_frame(input bit ack, input string tag);
    logic [9:0] rx;
    logic [9:0] exp;
    bit ok;
    rx = '0;
    wait_request(tag, ok);
    if (!ok) return;
    repeat (HALF) @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      if (i < 10) rx[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clock);
    end
    dev_data_low = 1'b0;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s_frame got %b want (scoreboard empty)", tag, rx);
    end else begin
      exp = exp_q.pop_front();
      if (rx !== exp) begin
        mismatched++;
        $display("FAIL %s_frame got %b want %b", tag, rx, exp);
      end
    end
  endtask

  task automatic device_partial(input int pulses, input string tag);
    bit ok;
    wait_request(tag, ok);
    if (!ok) return;
    repeat (HALF) @(negedge clock);
    for (int i = 0; i < pulses; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic wait_end(input int budget, input string tag, output bit got);
    int t;
    t = 0;
    got = 1'b0;
    while (t < budget) begin
      @(negedge clock);
      if (cmd_done || cmd_error) begin got = 1'b1; break; end
      t++;
    end
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL %s_end no done/error within %0d cycles", tag, budget);
    end
  endtask

  task automatic run_transfer(input logic [7:0] d, input bit ack, input string tag,
                              output int acc, output int d_done, output int d_err, output int busy_n);
    int done0, err0, busy0;
    bit got;
    done0 = done_cycles;
    err0  = error_cycles;
    busy0 = busy_cycles;
    exp_q.push_back({1'b1, ~^d, d});
    fork
      device_frame(ack, tag);
      begin
        send_cmd(d, acc);
        wait_end(20000, tag, got);
      end
    join
    repeat (3) @(negedge clock);
    d_done = done_cycles - done0;
    d_err  = error_cycles - err0;
    busy_n = busy_cycles - busy0;
  endtask

  // scenarios
  task automatic test_reset();
    resetn = 1'b0;
    cmd_send = 1'b0;
    repeat (5) @(negedge clock);
    compared++; if (cmd_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", cmd_busy); end
    compared++; if (cmd_done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", cmd_done); end
    compared++; if (cmd_error !== 1'b0) begin mismatched++; $display("FAIL reset_error got %b want 0", cmd_error); end
    compared++; if (ps2_clock_drive !== 1'b0) begin mismatched++; $display("FAIL reset_clock_drive got %b want 0", ps2_clock_drive); end
    compared++; if (ps2_data_drive !== 1'b0) begin mismatched++; $display("FAIL reset_data_drive got %b want 0", ps2_data_drive); end
    compared++; if (fsm_state !== 3'd0) begin mismatched++; $display("FAIL reset_state got %0d want 0", fsm_state); end
    resetn = 1'b1;
  endtask

  task automatic test_frame_ed();
    int acc, d_done, d_err, busy_n;
    run_transfer(8'hED, 1'b1, "ed", acc, d_done, d_err, busy_n);
    compared++; if (d_done !== 1) begin mismatched++; $display("FAIL ed_done_pulses got %0d want 1", d_done); end
    compared++; if (d_err !== 0) begin mismatched++; $display("FAIL ed_error_pulses got %0d want 0", d_err); end
    compared++; if (busy_rise_cyc !== acc) begin mismatched++; $display("FAIL ed_busy_rise got %0d want %0d", busy_rise_cyc, acc); end
  endtask

  task automatic test_parity_f4();
    int acc, d_done, d_err, busy_n;
    run_transfer(8'hF4, 1'b1, "f4", acc, d_done, d_err, busy_n);
    compared++; if (d_done !== 1) begin mismatched++; $display("FAIL f4_done_pulses got %0d want 1", d_done); end
    compared++; if (last_run !== INHIBIT) begin mismatched++; $display("FAIL f4_inhibit_len got %0d want %0d", last_run, INHIBIT); end
    compared++; if (start_run !== INHIBIT) begin mismatched++; $display("FAIL f4_start_bit_cycle got %0d want %0d", start_run, INHIBIT); end
    compared++; if (busy_rise_cyc !== acc) begin mismatched++; $display("FAIL f4_busy_rise got %0d want %0d", busy_rise_cyc, acc); end
    compared++; if (busy_n !== done_cyc - acc + 1) begin mismatched++; $display("FAIL f4_busy_len got %0d want %0d", busy_n, done_cyc - acc + 1); end
  endtask

  task automatic test_nack();
    int acc, d_done, d_err, busy_n;
    run_transfer(8'hA5, 1'b0, "nack", acc, d_done, d_err, busy_n);
    compared++; if (d_err !== 1) begin mismatched++; $display("FAIL nack_error_pulses got %0d want 1", d_err); end
    compared++; if (d_done !== 0) begin mismatched++; $display("FAIL nack_done_pulses got %0d want 0", d_done); end
    compared++; if (busy_n !== error_cyc - acc + 1) begin mismatched++; $display("FAIL nack_busy_len got %0d want %0d", busy_n, error_cyc - acc + 1); end
    compared++; if (cmd_busy !== 1'b0) begin mismatched++; $display("FAIL nack_idle_busy got %b want 0", cmd_busy); end
    compared++; if ({ps2_clock_drive, ps2_data_drive} !== 2'b00) begin mismatched++; $display("FAIL nack_drives got %b want 00", {ps2_clock_drive, ps2_data_drive}); end
  endtask

  task automatic test_repeat_send();
    int acc, d_done, d_err, busy_n, runs0;
    runs0 = inhibit_runs;
    fork
      run_transfer(8'h5A, 1'b1, "repeat", acc, d_done, d_err, busy_n);
      begin
        int t;
        t = 0;
        while (cmd_busy !== 1'b1 && t < 100) begin @(negedge clock); t++; end
        for (int k = 0; k < 5; k++) begin
          repeat ($urandom_range(200, 800)) @(negedge clock);
          cmd_data = 8'($urandom);
          cmd_send = 1'b1;
          @(negedge clock);
          cmd_send = 1'b0;
        end
        t = 0;
        while (dev_clk_low !== 1'b1 && t < 10000) begin @(negedge clock); t++; end
        repeat (HALF * 3) @(negedge clock);
        cmd_data = 8'h00;
        cmd_send = 1'b1;
        @(negedge clock);
        cmd_send = 1'b0;
      end
    join
    repeat (200) @(negedge clock);
    compared++; if (d_done !== 1) begin mismatched++; $display("FAIL repeat_done_pulses got %0d want 1", d_done); end
    compared++; if (inhibit_runs - runs0 !== 1) begin mismatched++; $display("FAIL repeat_frames got %0d want 1", inhibit_runs - runs0); end
    compared++; if (cmd_busy !== 1'b0) begin mismatched++; $display("FAIL repeat_no_queue busy got %b want 0", cmd_busy); end
  endtask

  task automatic test_random();
    int acc, d_done, d_err, busy_n;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    run_transfer(d, 1'b1, "random", acc, d_done, d_err, busy_n);
    compared++; if (d_done !== 1) begin mismatched++; $display("FAIL random_done_pulses got %0d want 1 (data %h)", d_done, d); end
  endtask

  task automatic test_no_clock();
    int acc, done0, err0;
    done0 = done_cycles;
    err0  = error_cycles;
    send_cmd(8'h12, acc);
`ifdef PS2_TX_TIMEOUT_EN
    begin
      bit got;
      wait_end(TB_TIMEOUT + 100, "watchdog", got);
      @(negedge clock);
      compared++; if (error_cyc !== acc + TB_TIMEOUT) begin mismatched++; $display("FAIL watchdog_cycle got %0d want %0d", error_cyc, acc + TB_TIMEOUT); end
    end
`else
    repeat (15000) @(negedge clock);
    compared++; if (cmd_busy !== 1'b1) begin mismatched++; $display("FAIL stall_busy got %b want 1", cmd_busy); end
    compared++; if (error_cycles - err0 !== 0) begin mismatched++; $display("FAIL stall_error_pulses got %0d want 0", error_cycles - err0); end
`endif
    compared++; if (done_cycles - done0 !== 0) begin mismatched++; $display("FAIL stall_done_pulses got %0d want 0", done_cycles - done0); end
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int acc, acc2, d_done, d_err, busy_n;
    fork
      device_partial(4, "mid");
      send_cmd(8'h3C, acc);
    join
    resetn = 1'b0;
    @(negedge clock);
    compared++; if ({ps2_clock_drive, ps2_data_drive} !== 2'b00) begin mismatched++; $display("FAIL mid_reset_drives got %b want 00", {ps2_clock_drive, ps2_data_drive}); end
    compared++; if (cmd_busy !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy got %b want 0", cmd_busy); end
    resetn = 1'b1;
    run_transfer(8'hFF, 1'b1, "ff", acc2, d_done, d_err, busy_n);
    compared++; if (busy_rise_cyc !== acc2) begin mismatched++; $display("FAIL ff_busy_rise got %0d want %0d", busy_rise_cyc, acc2); end
    compared++; if (d_done !== 1) begin mismatched++; $display("FAIL ff_done_pulses got %0d want 1", d_done); end
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_parity_f4();
    test_nack();
    test_repeat_send();
    test_random();
    test_no_clock();
    test_reset_mid();
    compared++; if (overlap !== 0) begin mismatched++; $display("FAIL done_error_overlap got %0d want 0", overlap); end
    compared++; if (idle_drive !== 0) begin mismatched++; $display("FAIL drive_outside_transfer got %0d want 0", idle_drive); end
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
